// File: rtl/digit_pkg.sv
// Shared definitions for the digit controller.
//   DIGIT_MAX / DIGIT_MIN : legal range of the displayed digit
//   mode_t                : operating mode (MANUAL steps on keys only, AUTO also ticks)
//   digit_inc / digit_dec : wrap-around decimal step helpers
package digit_pkg;

   localparam logic [3:0] DIGIT_MAX = 4'd9;
   localparam logic [3:0] DIGIT_MIN = 4'd0;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_AUTO   = 1'b1
   } mode_t;

   // Out-of-range inputs fold back to a legal digit rather than propagating.
   function automatic logic [3:0] digit_inc(input logic [3:0] d);
      return (d >= DIGIT_MAX) ? DIGIT_MIN : d + 4'd1;
   endfunction

   function automatic logic [3:0] digit_dec(input logic [3:0] d);
      return (d == DIGIT_MIN || d > DIGIT_MAX) ? DIGIT_MAX : d - 4'd1;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Key conditioner for one raw active-low board key.
//   sys_clk : system clock
//   sys_rst : synchronous active-high reset
//   key_n   : raw key, active-low, asynchronous to sys_clk
//   press   : registered one-cycle pulse on each accepted press (debounced 1->0)
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic key_n,
   output logic press
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q;
   logic            sync2_q;
   logic            deb_q;
   logic            deb_dly_q;
   logic            press_q;
   logic [CntW-1:0] cnt_q;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         deb_q     <= 1'b1;
         deb_dly_q <= 1'b1;
         press_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync1_q <= key_n;
         sync2_q <= sync1_q;
         // Any agreeing sample restarts the stability window.
         if (sync2_q == deb_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CntLast) begin
            deb_q <= sync2_q;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
         deb_dly_q <= deb_q;
         press_q   <= deb_dly_q & ~deb_q;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/digit_ctrl.sv
// Digit controller: debounces three keys and steps a 0-9 digit.
//   sys_clk     : system clock
//   sys_rst     : synchronous active-high reset
//   key_up_n    : raw up key, active-low
//   key_down_n  : raw down key, active-low
//   key_mode_n  : raw mode key, active-low (toggles MANUAL/AUTO)
//   display_num : current digit 0-9, registered
//   auto_mode   : 1 = AUTO, 0 = MANUAL, registered
//   num_changed : one-cycle pulse in the cycle display_num takes a new value
module digit_ctrl
   import digit_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned TICK_CYCLES     = 50_000_000
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       key_up_n,
   input  logic       key_down_n,
   input  logic       key_mode_n,
   output logic [3:0] display_num,
   output logic       auto_mode,
   output logic       num_changed
);

   localparam int unsigned TickW = $clog2(TICK_CYCLES);
   localparam logic [TickW-1:0] TickLast = TickW'(TICK_CYCLES - 1);

   logic up_press;
   logic down_press;
   logic mode_press;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .key_n   (key_up_n),
      .press   (up_press)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_down (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .key_n   (key_down_n),
      .press   (down_press)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .key_n   (key_mode_n),
      .press   (mode_press)
   );

   mode_t            mode_q, mode_d;
   logic [3:0]       num_q, num_d;
   logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
   logic             changed_q;
   logic             tick;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         mode_q     <= MODE_MANUAL;
         num_q      <= DIGIT_MIN;
         tick_cnt_q <= '0;
         changed_q  <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         num_q      <= num_d;
         tick_cnt_q <= tick_cnt_d;
         changed_q  <= (num_d != num_q);
      end
   end

   always_comb begin
      mode_d     = mode_q;
      num_d      = num_q;
      tick_cnt_d = '0;
      tick       = (mode_q == MODE_AUTO) && (tick_cnt_q == TickLast);

      // Tick counter only runs in AUTO; any key activity restarts the interval.
      if (mode_q == MODE_AUTO && !tick) begin
         tick_cnt_d = tick_cnt_q + 1'b1;
      end
      if (up_press || down_press || mode_press) begin
         tick_cnt_d = '0;
      end

      if (mode_press) begin
         unique case (mode_q)
            MODE_MANUAL: mode_d = MODE_AUTO;
            MODE_AUTO:   mode_d = MODE_MANUAL;
         endcase
      end

      // Collision of up and down cancels both and swallows any tick.
      if (up_press && down_press) begin
         num_d = num_q;
      end else if (up_press) begin
         num_d = digit_inc(num_q);
      end else if (down_press) begin
         num_d = digit_dec(num_q);
      end else if (tick) begin
         num_d = digit_inc(num_q);
      end
   end

   assign display_num = num_q;
   assign auto_mode   = (mode_q == MODE_AUTO);
   assign num_changed = changed_q;

endmodule

// File: doc/digit_ctrl.md
Name: digit_ctrl

Overview:
- Produces the 4-bit `display_num` (0-9) consumed by the LCD top level.
- Turns three raw, active-low board keys (up, down, mode) into debounced press events.
- Steps the digit on each press. An AUTO mode also increments the digit periodically from a prescaler.
- Runs on `sys_clk`, upstream of the PLL/LCD clock domain. The LCD side samples the quasi-static `display_num`.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable `sys_clk` samples required to accept a key level change (20 ms at 50 MHz). Minimum 2.
- TICK_CYCLES, 50_000_000: `sys_clk` cycles between AUTO-mode increments (1 s at 50 MHz). Minimum 2.

Ports:
- sys_clk  input  1  system clock.
- sys_rst  input  1  reset; synchronous, active-high.
- key_up_n  input  1  raw up key, active-low, asynchronous to `sys_clk`.
- key_down_n  input  1  raw down key, active-low, asynchronous.
- key_mode_n  input  1  raw mode key, active-low, asynchronous.
- display_num  output  4  current digit, 0-9, registered.
- auto_mode  output  1  1 = AUTO, 0 = MANUAL, registered.
- num_changed  output  1  one-cycle pulse in the cycle `display_num` takes a new value.

Behaviour:
- **Reset** (sys_rst=1 at an edge):
  - display_num=0, auto_mode=0, num_changed=0.
  - Synchronizer flops=1, debounced levels=1 (released), all counters=0.
  - A key held through reset produces one press event after release of reset, with normal latency.
- **Per key, in order:**
  - 2-flop synchronizer.
  - Debouncer: counter increments each cycle the synchronized level differs from the debounced level. Any cycle where they are equal clears the counter (bounce restarts). When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
  - Press event: registered one-cycle pulse on a debounced 1->0 transition. Release produces no event.
- **Latency:** key low sampled first at edge E, stable thereafter -> press pulse high after edge E+DEBOUNCE_CYCLES+2 -> display_num/num_changed update at edge E+DEBOUNCE_CYCLES+3.
- **State machine** (auto_mode is the state):
  - MANUAL -> AUTO on a mode press; AUTO -> MANUAL on a mode press.
  - Every mode toggle clears the tick counter.
  - A mode press does not change display_num.
- **Digit update** (one per cycle, priority in this order):
  - up and down presses in the same cycle: no change.
  - up press: display_num = (display_num==9) ? 0 : display_num+1.
  - down press: display_num = (display_num==0) ? 9 : display_num-1.
  - AUTO tick: same arithmetic as an up press.
  - An up/down press in AUTO clears the tick counter. If a tick and a press coincide, only the press is applied.
  - An up+down collision in AUTO also clears the tick counter and suppresses that tick.
- **Tick counter:**
  - Counts only in AUTO, from 0 to TICK_CYCLES-1.
  - The tick fires in the cycle it holds TICK_CYCLES-1, then the counter wraps to 0.
  - Held at 0 in MANUAL.
- **num_changed** is high only in the cycle display_num changes value. No pulse for a mode toggle or an up+down collision.
- **Invariant:** display_num never leaves 0-9.
- **Counter widths:** $clog2 of the respective parameter.

Decomposition:
- Shared package `digit_pkg`:
  - constant DIGIT_MAX=4'd9, DIGIT_MIN=4'd0.
  - typedef `mode_t` {MODE_MANUAL, MODE_AUTO}.
- One natural sub-module: `key_debounce` (parameter DEBOUNCE_CYCLES; ports sys_clk, sys_rst, key_n, press).
  - Contains the synchronizer, debouncer and press-pulse register.
  - Instantiated three times.
- Top level holds the mode FSM, tick counter and digit register.

Test Plan (DEBOUNCE_CYCLES=4, TICK_CYCLES=10):
1. Reset, then hold all keys high for 50 cycles -> display_num=0, auto_mode=0, num_changed never high.
2. key_up_n low first sampled at edge E, held, pressed 10 times with releases between presses -> display_num 1 at edge E+7, with a num_changed pulse; the sequence runs 1..9 then 0 on the 10th press. One down press from 0 -> 9.
3. key_up_n toggles low/high every 2 cycles for 20 cycles, then held high -> no press event, display_num unchanged.
4. Mode press -> auto_mode=1; display_num increments every 10 cycles (num_changed each time) and wraps 9->0. An up press mid-interval steps once and restarts the 10-cycle interval. A second mode press returns to MANUAL and stops counting.
5. key_up_n and key_down_n fall on the same edge and are held -> no change, no num_changed. In AUTO, this collision also delays the next tick by 10 cycles.
6. sys_rst asserted for 1 cycle while display_num=7, auto_mode=1 and a debounce is in progress -> next cycle display_num=0, auto_mode=0. A key held through reset yields exactly one press, DEBOUNCE_CYCLES+3 edges after the first post-reset edge.
